spart_fifo: RTL and testbench

- Parametrised successor to the spart: a UART with programmable baud divisor.
- Adds TX and RX FIFOs, configurable data width, sticky error flags and a readable status register.
- Sits between a processor/driver bus (iocs/iorw/ioaddr/tri-state databus) and the serial pins txd/rxd.
- Register map is kept compatible: 00 data, 01 status, 10 divisor low, 11 divisor high.

---
 rtl/spart_pkg.sv | 34 +++
 rtl/spart_fifo_buf.sv | 63 ++++++
 rtl/spart_fifo.sv | 279 +++++++++++++++++++++++++++
 tb/tb_spart_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for spart_fifo: register map, status bit positions and FSM states.
package spart_pkg;

  // Bus register addresses
  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  // Status register bit positions
  localparam int unsigned ST_RDA      = 0;
  localparam int unsigned ST_TBR      = 1;
  localparam int unsigned ST_TX_IDLE  = 2;
  localparam int unsigned ST_OVERRUN  = 3;
  localparam int unsigned ST_FRAMING  = 4;
  localparam int unsigned ST_PARITY   = 5;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/spart_fifo_buf.sv
// Synchronous FIFO used for both the TX and RX queues of spart_fifo.
// A pop is ignored when empty; a push is ignored when full unless a pop happens in the same cycle.
module spart_fifo_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Pointer/count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed: contents are only visible while non-empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/spart_fifo.sv
// spart_fifo: UART with programmable baud divisor, TX/RX FIFOs and sticky error flags.
// Optional even parity bit in both directions when SPART_PARITY_EN is defined.
module spart_fifo
  import spart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

`ifdef SPART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);

  logic wr_en, rd_en, status_rd, tick;
  logic [15:0] div_q, div_d, cnt_q, cnt_d;
  logic reload_q, reload_d;
  logic rda_q, rda_d, tbr_q, tbr_d;
  logic ovr_q, ovr_d, frm_q, frm_d, par_q, par_d;
  logic [7:0] rdata;

  logic tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_rdata;
  logic [CW-1:0] tx_count;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_rdata;
  logic [CW-1:0] rx_count;

  tx_state_e tx_state_q, tx_state_d;
  logic [3:0] tx_tick_q, tx_tick_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic tx_par_q, tx_par_d, tx_bit_end;

  rx_state_e rx_state_q, rx_state_d;
  logic [3:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic rx_fall, rx_mid, rx_end, ovr_set, frm_set, par_set;

  assign wr_en     = iocs && !iorw;
  assign rd_en     = iocs && iorw;
  assign status_rd = rd_en && (ioaddr == ADDR_STATUS);
  assign tick      = (cnt_q == '0);
  assign tx_push   = wr_en && (ioaddr == ADDR_DATA);
  assign rx_pop    = rd_en && (ioaddr == ADDR_DATA);
  assign rda       = rda_q;
  assign tbr       = tbr_q;
  assign databus   = rd_en ? rdata : 'z;

  spart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst), .push(tx_push), .pop(tx_pop), .wdata(databus[DATA_BITS-1:0]),
    .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  spart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_shift_q),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // Baud counter, divisor writes, registered rda/tbr and sticky flag next-state
  always_comb begin
    div_d    = div_q;
    reload_d = 1'b0;
    cnt_d    = (reload_q || tick) ? div_q : cnt_q - 16'd1;
    if (wr_en && ioaddr == ADDR_DBL) begin
      div_d[7:0] = databus;
      reload_d   = 1'b1;
    end
    if (wr_en && ioaddr == ADDR_DBH) begin
      div_d[15:8] = databus;
      reload_d    = 1'b1;
    end
    rda_d = (rx_count != '0);
    tbr_d = !tx_full;
    ovr_d = ovr_set ? 1'b1 : (status_rd ? 1'b0 : ovr_q);
    frm_d = frm_set ? 1'b1 : (status_rd ? 1'b0 : frm_q);
    par_d = par_set ? 1'b1 : (status_rd ? 1'b0 : par_q);
  end

  // Combinational read mux
  always_comb begin
    rdata = '0;
    case (ioaddr)
      ADDR_DATA:   if (!rx_empty) rdata[DATA_BITS-1:0] = rx_rdata;
      ADDR_STATUS: begin
        rdata[ST_RDA]     = rda_q;
        rdata[ST_TBR]     = tbr_q;
        rdata[ST_TX_IDLE] = (tx_count == '0) && (tx_state_q == TX_IDLE);
        rdata[ST_OVERRUN] = ovr_q;
        rdata[ST_FRAMING] = frm_q;
        rdata[ST_PARITY]  = PAR_EN && par_q;
      end
      ADDR_DBL:    rdata = div_q[7:0];
      default:     rdata = div_q[15:8];
    endcase
  end

  // Bus-side registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= DEFAULT_DIV;
      cnt_q    <= DEFAULT_DIV;
      reload_q <= 1'b0;
      rda_q    <= 1'b0;
      tbr_q    <= 1'b1;
      ovr_q    <= 1'b0;
      frm_q    <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      rda_q    <= rda_d;
      tbr_q    <= tbr_d;
      ovr_q    <= ovr_d;
      frm_q    <= frm_d;
      par_q    <= par_d;
    end
  end

  // TX next-state: frames start only on a tick so every bit spans exactly 16 ticks
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    tx_bit_end = tick && (tx_tick_q == 4'd15);
    if (tick) tx_tick_d = tx_tick_q + 4'd1;
    case (tx_state_q)
      TX_IDLE: begin
        tx_tick_d = '0;
        if (tick && !tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_rdata;
          tx_par_d   = ^tx_rdata;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == BIT_LAST) tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
        else                      tx_bit_d   = tx_bit_q + 3'd1;
      end
      TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
      TX_STOP: if (tx_bit_end) begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_rdata;
          tx_par_d   = ^tx_rdata;
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Serial output decoded from TX state
  always_comb begin
    case (tx_state_q)
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_shift_q[0];
      TX_PARITY: txd = tx_par_q;
      default:   txd = 1'b1;
    endcase
  end

  // TX registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  assign rx_fall = rx_prev_q && !rx_s2_q;
  assign rx_mid  = tick && (rx_tick_q == 4'd7);
  assign rx_end  = tick && (rx_tick_q == 4'd15);

  // RX next-state: start sampled at tick 8, then every 16 ticks; a framing error
  // needs rxd to return high before the next falling edge can be seen
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    ovr_set    = 1'b0;
    frm_set    = 1'b0;
    par_set    = 1'b0;
    if (tick) rx_tick_d = rx_tick_q + 4'd1;
    case (rx_state_q)
      RX_IDLE: begin
        rx_tick_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      RX_START: if (rx_mid) begin
        rx_tick_d  = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_end) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == BIT_LAST) rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
        else                      rx_bit_d   = rx_bit_q + 3'd1;
      end
      RX_PARITY: if (rx_end) begin
        par_set    = (rx_s2_q != ^rx_shift_q);
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_end) begin
        rx_state_d = RX_IDLE;
        if (rx_s2_q) begin
          rx_push = 1'b1;
          ovr_set = rx_full && !rx_pop;
        end else begin
          frm_set = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX registers including the rxd synchroniser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

endmodule

// File: tb/tb_spart_fifo.sv
// Self-checking bench for spart_fifo (default DATA_BITS=8, FIFO_DEPTH=8).
module tb_spart_fifo;

  localparam int BIT_CLKS = 64; // divisor 3 -> tick every 4 clocks, 16 ticks per bit

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0, iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  wire  [7:0] databus;
  logic [7:0] drv_data = 8'h00;
  logic       drv_oe = 1'b0;
  logic       rda, tbr, txd, rxd;
  logic       loop_en = 1'b1, rxd_drv = 1'b1, mon_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: bytes expected on txd and bytes expected in the RX FIFO
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic       ovr_exp = 1'b0;

  assign databus = drv_oe ? drv_data : 8'bz;
  assign rxd     = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  spart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd325)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_data = d; drv_oe = 1'b1;
    @(posedge clk);
    #1;
    iocs = 1'b0; drv_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1;
    d = databus;
    @(posedge clk);
    #1;
    iocs = 1'b0; iorw = 1'b0;
  endtask

  // Data read followed by settling time for the registered rda
  task automatic read_data(input string name, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(2'b00, d);
    check(name, d, exp);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rda(input int max, output int cyc);
    cyc = 0;
    while (rda !== 1'b1 && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    if (rda !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_rda: timeout after %0d cycles", max);
    end
  endtask

  // Queue a byte for transmission and record what loopback must deliver
  task automatic tx_send(input logic [7:0] b);
    tx_exp.push_back(b);
    if (loop_en) begin
      if (rx_exp.size() < 8) rx_exp.push_back(b);
      else                   ovr_exp = 1'b1;
    end
    bus_write(2'b00, b);
  endtask

  task automatic drive_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd_drv = bits[i];
      repeat (BIT_CLKS) @(posedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  // Compare process: decode every frame on txd and match it against the model queue
  initial begin : tx_monitor
    logic       prev;
    logic [7:0] got, exp;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !txd) begin
        repeat (BIT_CLKS/2 - 1) @(negedge clk);
        check("tx_start_bit", txd, 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (BIT_CLKS) @(negedge clk);
          got[k] = txd;
        end
        exp = (tx_exp.size() != 0) ? tx_exp.pop_front() : 8'hxx;
`ifdef SPART_PARITY_EN
        repeat (BIT_CLKS) @(negedge clk);
        check("tx_parity_bit", txd, ^exp);
`endif
        repeat (BIT_CLKS) @(negedge clk);
        check("tx_stop_bit", txd, 1'b1);
        check("tx_frame", got, exp);
      end
      prev = txd;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [7:0] d;
    int cyc;

    // Reset
    #2 rst = 1'b0;
    #1;
    check("rst_txd", txd, 1'b1);
    check("rst_rda", rda, 1'b0);
    check("rst_tbr", tbr, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus_read(2'b01, d); check("rst_status", d, 8'h06);
    bus_read(2'b10, d); check("rst_div_lo", d, 8'h45);
    bus_read(2'b11, d); check("rst_div_hi", d, 8'h01);

    // Divisor 3, single loopback frame
    bus_write(2'b10, 8'h03);
    bus_write(2'b11, 8'h00);
    bus_read(2'b10, d); check("div_lo_rb", d, 8'h03);
    mon_en = 1'b1;
    tx_send(8'h46);
    wait_rda(1500, cyc);
    check("rda_latency_ok", (cyc >= 580 && cyc <= 800), 1'b1);
    read_data("loop_data", rx_exp.pop_front());
    check("loop_rda_clear", rda, 1'b0);

    // Burst: stall the baud generator so nine writes meet an unmoving FIFO
    bus_write(2'b11, 8'hFF);
    for (int i = 0; i < 8; i++) tx_send(8'h10 + 8'(i));
    bus_write(2'b00, 8'h18);        // FIFO full: dropped
    repeat (2) @(negedge clk);
    check("burst_tbr_full", tbr, 1'b0);
    bus_read(2'b01, d); check("burst_status", d, 8'h00);
    bus_write(2'b11, 8'h00);
    for (int i = 0; i < 8; i++) begin
      wait_rda(1500, cyc);
      read_data("burst_data", rx_exp.pop_front());
    end
    check("burst_rda_clear", rda, 1'b0);

    // Overrun: nine frames arrive with nobody reading
    bus_write(2'b11, 8'hFF);
    for (int i = 0; i < 8; i++) tx_send(8'h20 + 8'(i));
    bus_write(2'b11, 8'h00);
    cyc = 0;
    while (tbr !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    check("ovr_tbr_free", tbr, 1'b1);
    tx_send(8'h28);
    repeat (7200) @(negedge clk);
    bus_read(2'b01, d); check("ovr_status", d, 8'h07 | {4'b0, ovr_exp, 3'b0});
    bus_read(2'b01, d); check("ovr_status_cleared", d, 8'h07);
    for (int i = 0; i < 8; i++) read_data("ovr_data", rx_exp.pop_front());
    check("ovr_rx_empty", rda, 1'b0);
    check("ovr_model_flag", ovr_exp, 1'b1);

    // Framing error: start, 0xA5 LSB first, stop bit 0
    loop_en = 1'b0;
    repeat (10) @(negedge clk);
`ifdef SPART_PARITY_EN
    drive_bits({5'b0, 1'b0, 1'b0, 8'hA5, 1'b0}, 11);
`else
    drive_bits({6'b0, 1'b0, 8'hA5, 1'b0}, 10);
`endif
    repeat (80) @(negedge clk);
    check("frm_rda", rda, 1'b0);
    bus_read(2'b01, d); check("frm_status", d, 8'h16);
    bus_read(2'b01, d); check("frm_status_cleared", d, 8'h06);

    // Reset in the middle of a TX frame (all-zero data keeps txd low through DATA)
    loop_en = 1'b1;
    mon_en  = 1'b0;
    bus_write(2'b00, 8'h00);
    bus_write(2'b00, 8'h44);
    repeat (120) @(negedge clk);
    check("pre_rst_txd", txd, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("midrst_txd", txd, 1'b1);
    check("midrst_rda", rda, 1'b0);
    check("midrst_tbr", tbr, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    bus_read(2'b01, d); check("midrst_status", d, 8'h06);
    bus_read(2'b10, d); check("midrst_div_lo", d, 8'h45);
    bus_write(2'b10, 8'h03);
    bus_write(2'b11, 8'h00);
    repeat (800) @(negedge clk);
    check("midrst_no_rx", rda, 1'b0);
    bus_read(2'b01, d); check("midrst_idle_status", d, 8'h06);

`ifdef SPART_PARITY_EN
    // Parity error: 0x01 needs parity 1, send 0; byte still delivered
    loop_en = 1'b0;
    repeat (10) @(negedge clk);
    drive_bits({5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11);
    wait_rda(200, cyc);
    bus_read(2'b01, d); check("par_status", d, 8'h27);
    read_data("par_data", 8'h01);
    loop_en = 1'b1;
`endif

    check("tx_model_drained", 16'(tx_exp.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
